mux4_rr_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one 4:1 single-bit mux datapath among 4 requesters.

---
 rtl/mux4_rr_arbiter_pkg.sv | 15 +
 rtl/mux4to1_str.sv | 18 +
 rtl/rr_pick4.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared constants and helpers for the 4-way round-robin mux arbiter
package mux4_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // One-hot grant vector for a requester index
    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4to1_str.sv
// rtl/mux4to1_str.sv - gate-level 4:1 single-bit multiplexer
module mux4to1_str (
    input  logic [3:0] i,
    input  logic [1:0] s,
    output logic       y
);

    logic [1:0] s_n;
    logic [3:0] t;

    assign s_n  = ~s;
    assign t[0] = i[0] & s_n[1] & s_n[0];
    assign t[1] = i[1] & s_n[1] & s[0];
    assign t[2] = i[2] & s[1]   & s_n[0];
    assign t[3] = i[3] & s[1]   & s[0];
    assign y    = |t;

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  off;

    // Doubling the vector lets a plain right shift act as a rotate by ptr
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NREQ-1:0];

    // Priority-encode the rotated vector, then add ptr back to un-rotate
    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign found = |rot;
    assign idx   = ptr + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter sharing one 4:1 bit mux, burst-limited grants
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             dout,
    output logic             dout_vld
);

    logic [0:0]       state_q,    state_d;
    logic [NREQ-1:0]  gnt_q,      gnt_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic             busy_q,     busy_d;
    logic             dout_q,     dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic [SEL_W-1:0] ptr_q,      ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             mux_y;
    logic             last_beat;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux4to1_str u_mux (
        .i (din),
        .s (sel_q),
        .y (mux_y)
    );

    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    // Next-state: arbitrate in IDLE, stream the granted bit and decide release in GRANT
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                dout_d     = mux_y;
                dout_vld_d = req[sel_q];
                // A req drop and the burst limit in the same cycle collapse into one release
                if (!req[sel_q] || last_beat) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule
